// File: rtl/sar_pkg.sv
// Shared types for the SAR readout controller: conversion and serializer FSM states.
package sar_pkg;
  localparam int SAR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT_EOC,
    GAP
  } conv_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } ser_state_t;
endpackage

// File: rtl/sar_rd_fifo.sv
// Small synchronous FIFO with first-word-fall-through read; a pop frees a slot for a same-cycle push.
module sar_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end
endmodule

// File: rtl/sar_readout_ctrl.sv
// Drives the sar_logic cnvst/eoc handshake, buffers captured codes and shifts them out as
// 8-bit serial frames (MSB first, data changes on sdo_clk falling edges).
module sar_readout_ctrl
  import sar_pkg::*;
#(
  parameter int PERIOD     = 32,
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int SCLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             clr_err,
  input  logic             eoc,
  input  logic [SAR_W-1:0] sar,
  output logic             cnvst,
  output logic             busy,
  output logic             sdo_cs_n,
  output logic             sdo_clk,
  output logic             sdo,
  output logic             overflow,
  output logic             timeout_err
);
  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(2 * SCLK_DIV);
  localparam int BW = $clog2(SAR_W);

  conv_state_t      conv_state_reg;
  ser_state_t       ser_state_reg;
  logic [PW-1:0]    period_cnt_reg;
  logic [TW-1:0]    to_cnt_reg;
  logic             gap_done_reg;
  logic [DW-1:0]    div_cnt_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic [SAR_W-1:0] shift_reg;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SAR_W-1:0] fifo_dout;
  logic             timeout_hit;
  logic             drop;

  assign fifo_push   = (conv_state_reg == WAIT_EOC) && eoc;
  assign timeout_hit = (conv_state_reg == WAIT_EOC) && !eoc && (to_cnt_reg == TW'(TIMEOUT - 1));
  assign fifo_pop    = (ser_state_reg == S_IDLE) && !fifo_empty;
  assign drop        = fifo_push && fifo_full && !fifo_pop;

  sar_rd_fifo #(
    .WIDTH(SAR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (sar),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // The period counter reads 0 during the TRIG cycle, so a GAP->TRIG decision at PERIOD-1
  // places successive cnvst pulses exactly PERIOD cycles apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_state_reg <= IDLE;
      cnvst          <= 1'b0;
      busy           <= 1'b0;
      period_cnt_reg <= '0;
      to_cnt_reg     <= '0;
      gap_done_reg   <= 1'b0;
    end else begin
      cnvst <= 1'b0;
      if (period_cnt_reg != PW'(PERIOD - 1)) period_cnt_reg <= period_cnt_reg + 1'b1;
      case (conv_state_reg)
        IDLE: begin
          if (en || start) begin
            conv_state_reg <= TRIG;
            cnvst          <= 1'b1;
            busy           <= 1'b1;
            period_cnt_reg <= '0;
          end
        end
        TRIG: begin
          conv_state_reg <= WAIT_EOC;
          to_cnt_reg     <= TW'(1);
        end
        WAIT_EOC: begin
          if (eoc || timeout_hit) begin
            conv_state_reg <= GAP;
            busy           <= 1'b0;
            gap_done_reg   <= 1'b0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          gap_done_reg <= 1'b1;
          if (!en) begin
            conv_state_reg <= IDLE;
          end else if (gap_done_reg && (period_cnt_reg == PW'(PERIOD - 1))) begin
            conv_state_reg <= TRIG;
            cnvst          <= 1'b1;
            busy           <= 1'b1;
            period_cnt_reg <= '0;
          end
        end
        default: conv_state_reg <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as clr_err takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (drop)        overflow    <= 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_state_reg <= S_IDLE;
      sdo_cs_n      <= 1'b1;
      sdo_clk       <= 1'b0;
      sdo           <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      div_cnt_reg   <= '0;
    end else begin
      case (ser_state_reg)
        S_IDLE: begin
          if (!fifo_empty) begin
            ser_state_reg <= S_SHIFT;
            sdo_cs_n      <= 1'b0;
            sdo           <= fifo_dout[SAR_W-1];
            shift_reg     <= fifo_dout;
            bit_cnt_reg   <= '0;
            div_cnt_reg   <= '0;
          end
        end
        S_SHIFT: begin
          if (div_cnt_reg == DW'(SCLK_DIV - 1)) begin
            div_cnt_reg <= '0;
            if (!sdo_clk) begin
              sdo_clk <= 1'b1;
            end else begin
              sdo_clk <= 1'b0;
              if (bit_cnt_reg == BW'(SAR_W - 1)) begin
                ser_state_reg <= S_HOLD;
                sdo_cs_n      <= 1'b1;
                sdo           <= 1'b0;
              end else begin
                shift_reg   <= {shift_reg[SAR_W-2:0], 1'b0};
                sdo         <= shift_reg[SAR_W-2];
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        S_HOLD: begin
          // HOLD plus the following IDLE cycle keep cs_n high for 2*SCLK_DIV cycles.
          if (div_cnt_reg == DW'(2 * SCLK_DIV - 2)) begin
            ser_state_reg <= S_IDLE;
            div_cnt_reg   <= '0;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        default: ser_state_reg <= S_IDLE;
      endcase
    end
  end
endmodule
